// File: rtl/pulse_wave_pkg.sv
// Shared widths and reset constants for the pulse/square wave generator.
// Imported by tick_divider and pulse_wave_gen.
package pulse_wave_pkg;

  localparam int DEF_DAC_W = 8;
  localparam int DEF_CNT_W = 9;
  localparam int DEF_DIV_W = 32;

  localparam logic [63:0] HI_RST = '1;
  localparam logic [63:0] LO_RST = '0;

endpackage

// File: rtl/tick_divider.sv
// Clock-enable prescaler: one tick every clk_div+1 cycles while enabled.
// Counter is cleared whenever enable is low so a restart begins cleanly.
import pulse_wave_pkg::*;

module tick_divider #(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  assign tick = enable && (div_cnt == clk_div);

  // count up to clk_div, restart on tick or while idle
  always_ff @(posedge clk) begin
    if (rst || !enable || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pulse_wave_gen.sv
// Pulse/square waveform generator with double-buffered settings.
// Optional PULSE_WAVE_SYNC_OUT_EN adds a one-cycle period-start trigger.
import pulse_wave_pkg::*;

module pulse_wave_gen #(
  parameter int DAC_W = DEF_DAC_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [DAC_W-1:0] level_hi,
  input  logic [DAC_W-1:0] level_lo,
  input  logic             load,
  output logic             load_ack,
`ifdef PULSE_WAVE_SYNC_OUT_EN
  output logic             sync_out,
`endif
  output logic [DAC_W-1:0] dac_out
);

  logic             tick;
  logic             wrap;
  logic             apply;
  logic [CNT_W-1:0] ph;

  logic             pending;
  logic [CNT_W-1:0] pend_period;
  logic [CNT_W-1:0] pend_duty;
  logic [DAC_W-1:0] pend_hi;
  logic [DAC_W-1:0] pend_lo;

  logic [CNT_W-1:0] period_s;
  logic [CNT_W-1:0] duty_s;
  logic [DAC_W-1:0] hi_s;
  logic [DAC_W-1:0] lo_s;

  tick_divider #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .clk_div (clk_div),
    .tick    (tick)
  );

  assign wrap  = tick && (ph >= period_s);
  assign apply = pending && (wrap || !enable);

  // capture strobe into pending set; last strobe wins
  always_ff @(posedge clk) begin
    if (rst) begin
      pending     <= 1'b0;
      pend_period <= '0;
      pend_duty   <= '0;
      pend_hi     <= HI_RST[DAC_W-1:0];
      pend_lo     <= LO_RST[DAC_W-1:0];
    end else if (load) begin
      pending     <= 1'b1;
      pend_period <= period;
      pend_duty   <= duty;
      pend_hi     <= level_hi;
      pend_lo     <= level_lo;
    end else if (apply) begin
      pending     <= 1'b0;
    end
  end

  // promote pending set to active shadows at a period boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      period_s <= '0;
      duty_s   <= '0;
      hi_s     <= HI_RST[DAC_W-1:0];
      lo_s     <= LO_RST[DAC_W-1:0];
      load_ack <= 1'b0;
    end else begin
      load_ack <= apply;
      if (apply) begin
        period_s <= pend_period;
        duty_s   <= pend_duty;
        hi_s     <= pend_hi;
        lo_s     <= pend_lo;
      end
    end
  end

  // phase counter, held at zero while idle
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      ph <= '0;
    end else if (tick) begin
      ph <= (ph >= period_s) ? '0 : ph + CNT_W'(1);
    end
  end

  // registered level select
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_out <= '0;
    end else begin
      dac_out <= (enable && (ph < duty_s)) ? hi_s : lo_s;
    end
  end

`ifdef PULSE_WAVE_SYNC_OUT_EN
  logic en_q;
  logic wrap_q;
  logic start;

  assign start = enable && (ph == '0) && (!en_q || wrap_q);

  // flag first ph=0 cycle, aligned with dac_out latency
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      wrap_q   <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      en_q     <= enable;
      wrap_q   <= wrap;
      sync_out <= start;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_wave_gen.sv
// Directed bench for pulse_wave_gen: waveform table plus
// hand-built load/enable/reset sequences.
module tb_pulse_wave_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] clk_div;
  logic [8:0]  period;
  logic [8:0]  duty;
  logic [7:0]  level_hi;
  logic [7:0]  level_lo;
  logic        load;
  logic        load_ack;
  logic [7:0]  dac_out;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] div;
    logic [8:0]  per;
    logic [8:0]  dut;
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] mask;
  } vec_t;

  vec_t tv[9];

  pulse_wave_gen dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .clk_div  (clk_div),
    .period   (period),
    .duty     (duty),
    .level_hi (level_hi),
    .level_lo (level_lo),
    .load     (load),
    .load_ack (load_ack),
    .dac_out  (dac_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [7:0] got, logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic stp_chk(string nm, logic [7:0] ed, logic ea);
    step();
    chk({nm, " dac"}, dac_out, ed);
    chk({nm, " ack"}, {7'd0, load_ack}, {7'd0, ea});
  endtask

  task automatic set_in(logic [8:0] p, logic [8:0] d,
                        logic [7:0] h, logic [7:0] l);
    period   = p;
    duty     = d;
    level_hi = h;
    level_lo = l;
  endtask

  task automatic run_cfg(string nm, logic [31:0] dv, logic [8:0] p,
                         logic [8:0] d, logic [7:0] h, logic [7:0] l);
    enable  = 1'b0;
    step();
    clk_div = dv;
    set_in(p, d, h, l);
    load = 1'b1;
    step();
    load = 1'b0;
    step();
    chk({nm, " cfg ack"}, {7'd0, load_ack}, 8'd1);
  endtask

  initial begin
    tv[0] = '{32'd0, 9'd3, 9'd2, 8'hFF, 8'h00, 16'b1100_1100_1100_1100};
    tv[1] = '{32'd1, 9'd3, 9'd2, 8'hFF, 8'h00, 16'b1111_0000_1111_0000};
    tv[2] = '{32'd0, 9'd3, 9'd0, 8'hFF, 8'h00, 16'b0000_0000_0000_0000};
    tv[3] = '{32'd0, 9'd3, 9'd5, 8'hFF, 8'h00, 16'b1111_1111_1111_1111};
    tv[4] = '{32'd0, 9'd0, 9'd1, 8'hFF, 8'h00, 16'b1111_1111_1111_1111};
    tv[5] = '{32'd0, 9'd1, 9'd1, 8'h80, 8'h10, 16'b1010_1010_1010_1010};
    tv[6] = '{32'd2, 9'd1, 9'd1, 8'h55, 8'hAA, 16'b1110_0011_1000_1110};
    tv[7] = '{32'd0, 9'd2, 9'd2, 8'h3C, 8'hC3, 16'b1101_1011_0110_1101};
    tv[8] = '{32'd0, 9'd4, 9'd4, 8'h01, 8'hFE, 16'b1111_0111_1011_1101};

    rst     = 1'b1;
    enable  = 1'b0;
    clk_div = '0;
    load    = 1'b0;
    set_in(9'd0, 9'd0, 8'h00, 8'h00);
    repeat (3) step();
    chk("reset dac", dac_out, 8'h00);
    chk("reset ack", {7'd0, load_ack}, 8'd0);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run_cfg($sformatf("v%0d", v), tv[v].div, tv[v].per,
              tv[v].dut, tv[v].hi, tv[v].lo);
      enable = 1'b1;
      for (int s = 0; s < 16; s++) begin
        step();
        chk($sformatf("v%0d s%0d", v, s), dac_out,
            tv[v].mask[15-s] ? tv[v].hi : tv[v].lo);
      end
    end

    run_cfg("mid", 32'd0, 9'd3, 9'd2, 8'hFF, 8'h00);
    enable = 1'b1;
    stp_chk("mid e0", 8'hFF, 1'b0);
    set_in(9'd1, 9'd1, 8'h80, 8'h10);
    load = 1'b1;
    stp_chk("mid e1", 8'hFF, 1'b0);
    load = 1'b0;
    stp_chk("mid e2", 8'h00, 1'b0);
    stp_chk("mid e3", 8'h00, 1'b1);
    stp_chk("mid e4", 8'h80, 1'b0);
    stp_chk("mid e5", 8'h10, 1'b0);
    stp_chk("mid e6", 8'h80, 1'b0);

    set_in(9'd3, 9'd2, 8'hFF, 8'h00);
    load = 1'b1;
    stp_chk("two e7", 8'h10, 1'b0);
    set_in(9'd2, 9'd1, 8'h44, 8'h22);
    stp_chk("two e8", 8'h80, 1'b0);
    load = 1'b0;
    stp_chk("two e9", 8'h10, 1'b1);
    stp_chk("two e10", 8'h44, 1'b0);
    stp_chk("two e11", 8'h22, 1'b0);
    stp_chk("two e12", 8'h22, 1'b0);

    enable = 1'b0;
    stp_chk("off 0", 8'h22, 1'b0);
    stp_chk("off 1", 8'h22, 1'b0);
    enable = 1'b1;
    stp_chk("reen 0", 8'h44, 1'b0);
    stp_chk("reen 1", 8'h22, 1'b0);
    stp_chk("reen 2", 8'h22, 1'b0);
    stp_chk("reen 3", 8'h44, 1'b0);

    set_in(9'd3, 9'd2, 8'hFF, 8'h00);
    load = 1'b1;
    stp_chk("rst ld", 8'h22, 1'b0);
    load = 1'b0;
    rst  = 1'b1;
    stp_chk("rst 0", 8'h00, 1'b0);
    rst  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stp_chk($sformatf("post rst %0d", i), 8'h00, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
